hdmi_line_prefetch: RTL

HDMI_LINE_PREFETCH -- requirements
Module: hdmi_line_prefetch

---
 rtl/hdmi_line_prefetch.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/hdmi_line_prefetch.sv
// hdmi_line_prefetch
// Prefetches the next display line from a linear frame buffer into a
// ping-pong line buffer. It issues fixed-length read bursts just after the
// encoder passes the end of the active part of a line. The display buffer is
// swapped at the start of the next active line.
//
// Parameters
//   FB_BASE          byte address of pixel (0,0)
//   LINE_STRIDE      bytes between successive lines
//   BURST_BEATS      4-byte pixels per burst (power of two, 1..256)
//   MAX_OUTSTANDING  accepted-but-incomplete bursts allowed (1..15)
//
// Ports
//   clk_pixel, reset_n              pixel clock, async active-low reset
//   enable                          prefetching allowed while high
//   cx, cy                          current encoder pixel position
//   screen_width/height             active area size
//   frame_height                    total lines per frame
//   rd_req_valid/ready/addr/len     burst read request handshake
//   rd_done                         one pulse per burst landed in the buffer
//   buf_sel                         buffer read by the display
//   underrun, underrun_clr          sticky late-line flag and its clear
module hdmi_line_prefetch #(
   parameter logic [31:0] FB_BASE         = 32'h1000_0000,
   parameter int unsigned LINE_STRIDE     = 10240,
   parameter int unsigned BURST_BEATS     = 16,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic        clk_pixel,
   input  logic        reset_n,
   input  logic        enable,
   input  logic [11:0] cx,
   input  logic [11:0] cy,
   input  logic [11:0] screen_width,
   input  logic [11:0] screen_height,
   input  logic [11:0] frame_height,
   output logic        rd_req_valid,
   input  logic        rd_req_ready,
   output logic [31:0] rd_req_addr,
   output logic [7:0]  rd_req_len,
   input  logic        rd_done,
   output logic        buf_sel,
   output logic        underrun,
   input  logic        underrun_clr
);

   typedef enum logic [1:0] {IDLE, WAIT_TRIG, ISSUE, DRAIN} state_t;

   localparam logic [7:0]  LEN     = 8'(BURST_BEATS - 1);
   localparam logic [12:0] STEP    = 13'(BURST_BEATS);
   localparam logic [3:0]  MAX_OUT = 4'(MAX_OUTSTANDING);

   state_t      state;
   logic [3:0]  outstanding;
   logic [12:0] offset;      // pixel offset of the next burst within the line
   logic [31:0] line_base;
   logic [31:0] pend_base;   // base of the line to start once a stale line drains
   logic        fill_done;
   logic        stale;

   logic        trigger;
   logic        disp_start;
   logic        handshake;
   logic        hold;
   logic [12:0] cy_plus1;
   logic [11:0] target;
   logic [31:0] target_base;
   logic [3:0]  out_next;
   logic [12:0] off_next;

   // The burst length never changes, so it is a constant output.
   assign rd_req_len = LEN;

   // 13-bit compare keeps a zero screen_height from wrapping.
   assign cy_plus1    = {1'b0, cy} + 13'd1;
   assign trigger     = (cx == screen_width) &&
                        ((cy_plus1 < {1'b0, screen_height}) || (cy == frame_height - 12'd1));
   assign target      = (cy == frame_height - 12'd1) ? 12'd0 : cy + 12'd1;
   assign target_base = FB_BASE + 32'(target) * 32'(LINE_STRIDE);
   assign disp_start  = (cx == 12'd0) && (cy < screen_height);

   assign handshake = rd_req_valid & rd_req_ready;
   // An offered request must stay put until it is accepted.
   assign hold      = rd_req_valid & ~rd_req_ready;
   // rd_done with nothing outstanding is a leftover from before a reset.
   assign out_next  = outstanding + {3'b000, handshake}
                      - {3'b000, (rd_done && (outstanding != 4'd0))};
   assign off_next  = handshake ? offset + STEP : offset;

   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         rd_req_valid <= 1'b0;
         rd_req_addr  <= 32'd0;
         buf_sel      <= 1'b0;
         underrun     <= 1'b0;
         outstanding  <= 4'd0;
         offset       <= 13'd0;
         line_base    <= 32'd0;
         pend_base    <= 32'd0;
         fill_done    <= 1'b0;
         stale        <= 1'b0;
      end else begin
         outstanding <= out_next;
         offset      <= off_next;

         // Display side runs in every state. Assignments to fill_done made
         // by the FSM below take precedence over the swap-time clear.
         if (disp_start && fill_done) begin
            buf_sel   <= ~buf_sel;
            fill_done <= 1'b0;
         end
         if (disp_start && !fill_done)
            underrun <= 1'b1;
         else if (underrun_clr)
            underrun <= 1'b0;

         case (state)
            IDLE: begin
               rd_req_valid <= 1'b0;
               fill_done    <= 1'b0;
               stale        <= 1'b0;
               if (enable)
                  state <= WAIT_TRIG;
            end

            WAIT_TRIG: begin
               if (!enable) begin
                  state     <= IDLE;
                  fill_done <= 1'b0;
               end else if (trigger) begin
                  state     <= ISSUE;
                  line_base <= target_base;
                  offset    <= 13'd0;
                  fill_done <= 1'b0;
               end
            end

            ISSUE: begin
               if (trigger) begin
                  stale     <= 1'b1;
                  pend_base <= target_base;
               end
               if (!hold) begin
                  if (stale || trigger || !enable || (off_next >= {1'b0, screen_width})) begin
                     rd_req_valid <= 1'b0;
                     state        <= DRAIN;
                  end else if (out_next < MAX_OUT) begin
                     rd_req_valid <= 1'b1;
                     rd_req_addr  <= line_base + {17'd0, off_next, 2'b00};
                  end else begin
                     rd_req_valid <= 1'b0;
                  end
               end
            end

            DRAIN: begin
               if (trigger) begin
                  stale     <= 1'b1;
                  pend_base <= target_base;
               end
               if (outstanding == 4'd0) begin
                  if (!enable) begin
                     state     <= IDLE;
                     stale     <= 1'b0;
                     fill_done <= 1'b0;
                  end else if (stale || trigger) begin
                     // Abandon the stale line and go straight to the new one.
                     state     <= ISSUE;
                     line_base <= trigger ? target_base : pend_base;
                     offset    <= 13'd0;
                     stale     <= 1'b0;
                  end else begin
                     fill_done <= 1'b1;
                     state     <= WAIT_TRIG;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
